instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage between program_memory and the idec/eucl pair. Owns the fetch PC, issues
//   synchronous reads to program memory, and buffers up to 2 fetched 32-bit words in a FIFO.
//   Presents the head word with valid/ack handshaking. Flushes on branch/jump redirect.
//   Stops fetching on EOP (opcode 5'b00000).
// PARAMETERS
//   PC_W     8   fetch/branch address width (256-word program memory)
//   INSTR_W  32  instruction word width
//   DEPTH    2   prefetch FIFO entries (design verified at 2 only)
// PORTS
//   clock        in   1        single clock; all state updates on posedge
//   reset        in   1        synchronous, active-high
//   pm_addr      out  PC_W     program memory read address (= fetch_pc)
//   pm_rd        out  1        read issue; pm_data is valid in the following cycle
//   pm_data      in   INSTR_W  read data from program memory
//   instr        out  INSTR_W  head-of-FIFO instruction word (0 when empty)
//   instr_pc     out  PC_W     PC of the head instruction
//   instr_valid  out  1        head entry present
//   instr_ack    in   1        consumer retires head this cycle; ignored when !instr_valid
//   redirect     in   1        branch/jump taken: flush everything
//   redirect_pc  in   PC_W     target PC, sampled when redirect=1
//   halt         out  1        EOP at head; fetching stopped
// BEHAVIOUR
//   - Reset: fetch_pc=0, FIFO empty, in-flight cleared, state=RUN.
//     Outputs while reset=1: pm_rd=0, pm_addr=0, instr=0, instr_pc=0, instr_valid=0, halt=0.
//   - FSM states:
//       RUN:  normal fetching.
//       HALT: entered on the edge where the FIFO head has instr[4:0]==5'b00000.
//             pm_rd=0; halt=1; instr_valid stays 1 with the EOP word.
//             instr_ack is ignored; the EOP word is never retired.
//             Exits to RUN only on redirect; reset also returns to RUN.
//   - Credit rule: in RUN, pm_rd=1 when (occupancy + inflight - (instr_ack & instr_valid)) < DEPTH.
//     inflight is 1 in the cycle after a pm_rd.
//     Each issue post-increments fetch_pc by 1 (mod 2^PC_W).
//   - Return path: the cycle after pm_rd, pm_data is written to the FIFO tail, tagged with its PC.
//     The write happens at the end of that cycle. The write is skipped if that read was killed.
//   - Latency: reset drops before cycle 0.
//       cycle 0: pm_rd=1, pm_addr=0
//       cycle 1: pm_data returned
//       cycle 2: instr_valid=1, instr_pc=0
//   - Simultaneous FIFO write and instr_ack: both take effect; occupancy is unchanged.
//     No overflow is possible under the credit rule. Write to a full FIFO is an assertion error.
//   - Redirect in cycle N: at the edge, FIFO is flushed, the in-flight read is killed,
//     fetch_pc<=redirect_pc, state<=RUN.
//       cycle N+1: pm_rd=1, pm_addr=redirect_pc
//       cycle N+3: instr_valid=1
//     pm_rd is forced 0 in cycle N.
//   - redirect together with instr_ack: redirect wins; the ack has no extra effect.
//   - Wrap-around: fetch_pc 8'hFF issues, then 8'h00. No special handling.
//   - Reset asserted mid-operation: all state cleared on that edge; in-flight data is discarded.
// TESTING
//   1. Reset, then hold instr_ack=1 with PM[0..3]=A,B,C,D (non-EOP).
//      -> instr_valid first at cycle 2; A,B,C,D delivered one per cycle with instr_pc 0..3.
//   2. Hold instr_ack=0.
//      -> after 2 issues, pm_rd stays 0; instr=A stays stable.
//      Release ack -> B, then C, with no word lost or duplicated.
//   3. redirect=1, redirect_pc=8'h40, asserted while FIFO is full and a read is in flight.
//      -> the next instr_valid word has instr_pc=8'h40, 3 cycles later; stale words are never presented.
//   4. PM[2]=32'h0 (EOP).
//      -> halt=1 once it reaches the head; pm_rd=0; ack ignored for 10 cycles.
//      Then redirect to 0 -> halt=0 and fetching restarts.
//   5. Redirect to 8'hFE.
//      -> instr_pc sequence FE, FF, 00, 01.
//   6. Assert reset for 1 cycle mid-stream, with a FIFO write pending.
//      -> next cycle instr_valid=0; first valid afterwards has instr_pc=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, program memory reads, 2-entry prefetch FIFO, redirect and EOP halt
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    pm_addr,
  output logic               pm_rd,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t           fifo     [DEPTH];
  entry_t           fifo_nxt [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W:0]   used;
  logic             inflight;
  logic [PC_W-1:0]  inflight_pc;
  logic [PC_W-1:0]  fetch_pc;
  state_t           state;
  logic             head_valid;
  logic             head_eop;
  logic             pop;

  assign head_valid = (count != '0);
  assign head_eop   = (fifo[0].data[4:0] == 5'b00000);

  // An EOP word at the head is never retired, so it must not free a credit either.
  assign pop    = (state == ST_RUN) && head_valid && instr_ack && !head_eop;
  assign used   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign wr_idx = count - CNT_W'(pop);

  assign pm_rd       = !reset && (state == ST_RUN) && !redirect && (used < (CNT_W+1)'(DEPTH));
  assign pm_addr     = reset ? '0 : fetch_pc;
  assign instr_valid = !reset && head_valid;
  assign instr       = instr_valid ? fifo[0].data : '0;
  assign instr_pc    = instr_valid ? fifo[0].pc : '0;
  assign halt        = !reset && (state == ST_HALT);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) fifo_nxt[i] = fifo[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) fifo_nxt[i] = fifo[i+1];
    end
    if (inflight) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) fifo_nxt[i] = '{data: pm_data, pc: inflight_pc};
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) fifo[i] <= fifo_nxt[i];
  end

  // Reset and redirect both flush the FIFO and kill the read whose data returns next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      fetch_pc    <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      state    <= ST_RUN;
      fetch_pc <= redirect_pc;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      assert (!(inflight && count == CNT_W'(DEPTH) && !pop));
      inflight <= pm_rd;
      if (pm_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_W'(1);
      end
      count <= count + CNT_W'(inflight) - CNT_W'(pop);
      if (state == ST_RUN && head_valid && head_eop) state <= ST_HALT;
    end
  end

endmodule
